// File: rtl/ssd_scan_mux.sv
// Multi-digit seven-segment scan driver: internal prescaler, load-strobed value latch,
// leading-zero blanking, dash/blank codes, per-digit decimal points and whole-display blink.
module ssd_scan_mux #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SCAN_DIV     = 8192,
   parameter int unsigned BLINK_FRAMES = 32,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] bcd,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic                    load,
   input  logic                    lz_blank,
   input  logic                    blink_en,
   output logic [NUM_DIGITS-1:0]   DIGIT,
   output logic [6:0]              DISPLAY,
   output logic                    DP_OUT
);

   localparam int unsigned TW = $clog2(SCAN_DIV);
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   typedef enum logic {PH_ON, PH_OFF} phase_t;

   logic [TW-1:0]           tick_q, tick_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [FW-1:0]           fcnt_q, fcnt_d;
   phase_t                  phase_q, phase_d;
   logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
   logic [NUM_DIGITS-1:0]   dp_q, dp_d;
   logic                    lz_q, lz_d;
   logic [NUM_DIGITS-1:0]   digit_q, digit_d;
   logic [6:0]              display_q, display_d;
   logic                    dp_out_q, dp_out_d;

   logic                    tick_wrap, idx_last, frame_wrap;
   logic [NUM_DIGITS-1:0]   lead_zero;
   logic                    zero_run;
   logic [3:0]              code;
   logic [6:0]              glyph;
   logic [NUM_DIGITS-1:0]   digit_hi;

   function automatic logic [6:0] seg_decode(input logic [3:0] c);
      case (c)
         4'd0:    seg_decode = 7'h3F;
         4'd1:    seg_decode = 7'h06;
         4'd2:    seg_decode = 7'h5B;
         4'd3:    seg_decode = 7'h4F;
         4'd4:    seg_decode = 7'h66;
         4'd5:    seg_decode = 7'h6D;
         4'd6:    seg_decode = 7'h7D;
         4'd7:    seg_decode = 7'h07;
         4'd8:    seg_decode = 7'h7F;
         4'd9:    seg_decode = 7'h6F;
         4'd11:   seg_decode = 7'h40;
         default: seg_decode = 7'h00;
      endcase
   endfunction

   always_comb begin
      tick_wrap  = (tick_q == TW'(SCAN_DIV - 1));
      idx_last   = (idx_q == IW'(NUM_DIGITS - 1));
      frame_wrap = tick_wrap & idx_last;

      tick_d = tick_wrap ? '0 : tick_q + 1'b1;
      idx_d  = idx_q;
      if (tick_wrap) idx_d = idx_last ? '0 : idx_q + 1'b1;

      bcd_d = bcd_q;
      dp_d  = dp_q;
      lz_d  = lz_q;
      fcnt_d  = fcnt_q;
      phase_d = phase_q;
      // load overrides any blink toggle on the same edge
      if (load) begin
         bcd_d   = bcd;
         dp_d    = dp;
         lz_d    = lz_blank;
         fcnt_d  = '0;
         phase_d = PH_ON;
      end else if (!blink_en) begin
         fcnt_d  = '0;
         phase_d = PH_ON;
      end else if (frame_wrap) begin
         if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
            fcnt_d  = '0;
            phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      // lead_zero[i]: digit i and every digit above it hold code 0
      zero_run  = 1'b1;
      lead_zero = '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         zero_run = zero_run & (bcd_q[(NUM_DIGITS-1-k)*4 +: 4] == 4'd0);
         lead_zero[NUM_DIGITS-1-k] = zero_run;
      end

      code  = bcd_q[{idx_q, 2'b00} +: 4];
      glyph = seg_decode(code);
      if (lz_q && lead_zero[idx_q] && (idx_q != '0)) glyph = 7'h00;

      digit_hi = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++)
         digit_hi[i] = (phase_q == PH_ON) && (idx_q == IW'(i));

      digit_d   = {NUM_DIGITS{ACTIVE_LOW}} ^ digit_hi;
      display_d = {7{ACTIVE_LOW}} ^ glyph;
      dp_out_d  = ACTIVE_LOW ^ dp_q[idx_q];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_q    <= '0;
         idx_q     <= '0;
         fcnt_q    <= '0;
         phase_q   <= PH_ON;
         bcd_q     <= {NUM_DIGITS{4'hA}};
         dp_q      <= '0;
         lz_q      <= 1'b0;
         digit_q   <= {NUM_DIGITS{ACTIVE_LOW}};
         display_q <= {7{ACTIVE_LOW}};
         dp_out_q  <= ACTIVE_LOW;
      end else begin
         tick_q    <= tick_d;
         idx_q     <= idx_d;
         fcnt_q    <= fcnt_d;
         phase_q   <= phase_d;
         bcd_q     <= bcd_d;
         dp_q      <= dp_d;
         lz_q      <= lz_d;
         digit_q   <= digit_d;
         display_q <= display_d;
         dp_out_q  <= dp_out_d;
      end
   end

   assign DIGIT   = digit_q;
   assign DISPLAY = display_q;
   assign DP_OUT  = dp_out_q;

endmodule
